// File: rtl/brm_pkg.sv
// Shared types and constants for the multi-channel binary rate multiplier.
package brm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } brm_state_t;

  localparam int unsigned BRM_WIDTH   = 16;
  localparam int unsigned BRM_STAGE_W = 4;
  localparam int unsigned NSTAGE      = BRM_WIDTH / BRM_STAGE_W;

  typedef logic [BRM_WIDTH:0] brm_rate_t;

  function automatic int unsigned nstage(input int unsigned width, input int unsigned stage_w);
    return width / stage_w;
  endfunction

endpackage

// File: rtl/brm_lsb_decode.sv
// Lowest-set-bit one-hot of the counter, built slice by slice; a slice only
// contributes when every lower slice is all-zero.
module brm_lsb_decode
  import brm_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned STAGE_W = 4
) (
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] onehot
);

  localparam int unsigned NS = nstage(WIDTH, STAGE_W);

  logic               lower_zero;
  logic [STAGE_W-1:0] slice;

  always_comb begin
    onehot     = '0;
    lower_zero = 1'b1;
    slice      = '0;
    for (int unsigned s = 0; s < NS; s++) begin
      slice = x[s*STAGE_W +: STAGE_W];
      // v & -v isolates the lowest set bit within the slice
      onehot[s*STAGE_W +: STAGE_W] = lower_zero ? (slice & (~slice + STAGE_W'(1))) : '0;
      lower_zero = lower_zero & ~(|slice);
    end
  end

endmodule

// File: rtl/brm_multichan.sv
// Multi-channel binary rate multiplier: one shared enable-gated counter, per-channel
// double-buffered rate words, run/one-shot control and registered pulse outputs.
module brm_multichan
  import brm_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned STAGE_W  = 4,
  parameter int unsigned CHANNELS = 2,
  localparam int unsigned CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                CK,
  input  logic                RST,
  input  logic                P_0,
  input  logic                MODE,
  input  logic                START,
  input  logic                STOP,
  input  logic                RATE_WE,
  input  logic [CH_W-1:0]     RATE_CH,
  input  logic [WIDTH:0]      RATE_DATA,
  output logic [CHANNELS-1:0] Z,
  output logic [WIDTH-1:0]    CNT,
  output logic                BUSY,
  output logic                DONE,
  output logic                WRAP
);

  typedef logic [WIDTH:0] rate_t;

  brm_state_t          state, state_nxt;
  logic [WIDTH-1:0]    x, x_nxt;
  logic                mode_q, mode_nxt;
  rate_t               rate_sh  [CHANNELS];
  rate_t               rate_act [CHANNELS];
  logic                advance;
  logic                at_top;
  logic                load_act;
  logic [WIDTH-1:0]    onehot;
  logic [WIDTH:0]      term;
  logic [CHANNELS-1:0] z_nxt;

  brm_lsb_decode #(
    .WIDTH  (WIDTH),
    .STAGE_W(STAGE_W)
  ) u_decode (
    .x     (x),
    .onehot(onehot)
  );

  assign at_top = &x;
  assign term   = {onehot, 1'b1};

  always_comb begin
    state_nxt = state;
    x_nxt     = x;
    mode_nxt  = mode_q;
    advance   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (START && !STOP) begin
          state_nxt = ST_RUN;
          x_nxt     = '0;
          mode_nxt  = MODE;
        end
      end
      ST_RUN: begin
        if (STOP) begin
          state_nxt = ST_IDLE;
          x_nxt     = '0;
        end else if (P_0) begin
          advance = 1'b1;
          x_nxt   = x + WIDTH'(1);
          if (at_top && mode_q) state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Active rates track the shadow copy whenever idle, and switch over only on the wrap advance while running
  assign load_act = (state != ST_RUN) || (advance && at_top);

  always_comb begin
    z_nxt = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      z_nxt[c] = advance & (|(term & rate_act[c]));
    end
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state  <= ST_IDLE;
      x      <= '0;
      mode_q <= 1'b0;
      Z      <= '0;
      WRAP   <= 1'b0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        rate_sh[c]  <= '0;
        rate_act[c] <= '0;
      end
    end else begin
      state  <= state_nxt;
      x      <= x_nxt;
      mode_q <= mode_nxt;
      Z      <= z_nxt;
      WRAP   <= advance & at_top;
      if (load_act) begin
        for (int unsigned c = 0; c < CHANNELS; c++) rate_act[c] <= rate_sh[c];
      end
      if (RATE_WE && (32'(RATE_CH) < CHANNELS)) rate_sh[RATE_CH] <= RATE_DATA;
    end
  end

  assign CNT  = x;
  assign BUSY = (state == ST_RUN);
  assign DONE = (state == ST_DONE);

endmodule

// File: tb/tb_brm_multichan.sv
// Directed and randomized bench for brm_multichan (WIDTH=4, STAGE_W=2, CHANNELS=2)
// against a cycle-level behavioural model of the pulse-rate rules.
module tb_brm_multichan;

  localparam int W    = 4;
  localparam int NCH  = 2;
  localparam int TOPX = (1 << W) - 1;

  logic       CK = 1'b0;
  logic       RST, P_0, MODE, START, STOP, RATE_WE;
  logic [0:0] RATE_CH;
  logic [4:0] RATE_DATA;
  logic [1:0] Z;
  logic [3:0] CNT;
  logic       BUSY, DONE, WRAP;

  brm_multichan #(
    .WIDTH   (4),
    .STAGE_W (2),
    .CHANNELS(2)
  ) dut (
    .CK       (CK),
    .RST      (RST),
    .P_0      (P_0),
    .MODE     (MODE),
    .START    (START),
    .STOP     (STOP),
    .RATE_WE  (RATE_WE),
    .RATE_CH  (RATE_CH),
    .RATE_DATA(RATE_DATA),
    .Z        (Z),
    .CNT      (CNT),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .WRAP     (WRAP)
  );

  always #5 CK = ~CK;

  int total = 0, passed = 0, fails = 0;
  int cnt_z0, cnt_z1, cnt_w, wrap_at;

  // model: 0 idle, 1 run, 2 done
  int m_state, m_x, m_mode, m_z, m_wrap;
  int m_sh[NCH];
  int m_act[NCH];

  // pulse when rate bit 0 is set, or when bit (trailing zeros of x)+1 is set
  function automatic int pulse(input int rate, input int xv);
    int v, k;
    if (xv == 0) return rate & 1;
    v = xv;
    k = 0;
    while (v % 2 == 0) begin
      v = v / 2;
      k++;
    end
    return ((rate & 1) != 0 || ((rate >> (k + 1)) & 1) != 0) ? 1 : 0;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int  nz;
    bit  adv, top;
    if (RST) begin
      m_state = 0; m_x = 0; m_mode = 0; m_z = 0; m_wrap = 0;
      for (int c = 0; c < NCH; c++) begin
        m_sh[c]  = 0;
        m_act[c] = 0;
      end
    end else begin
      adv = (m_state == 1) && !STOP && P_0;
      top = (m_x == TOPX);
      nz  = 0;
      for (int c = 0; c < NCH; c++)
        if (adv && pulse(m_act[c], m_x) != 0) nz |= (1 << c);
      m_z    = nz;
      m_wrap = (adv && top) ? 1 : 0;
      if (m_state != 1 || (adv && top))
        for (int c = 0; c < NCH; c++) m_act[c] = m_sh[c];
      if (RATE_WE && int'(RATE_CH) < NCH) m_sh[int'(RATE_CH)] = int'(RATE_DATA);
      case (m_state)
        0: if (START && !STOP) begin m_state = 1; m_x = 0; m_mode = int'(MODE); end
        1: begin
          if (STOP) begin
            m_state = 0; m_x = 0;
          end else if (P_0) begin
            m_x = (m_x + 1) % (TOPX + 1);
            if (top && m_mode != 0) m_state = 2;
          end
        end
        default: m_state = 0;
      endcase
    end
  endtask

  task automatic step(input bit rst, input bit p, input bit st, input bit sp, input bit md,
                      input bit we, input int ch, input int data);
    RST = rst; P_0 = p; START = st; STOP = sp; MODE = md; RATE_WE = we;
    RATE_CH = 1'(ch); RATE_DATA = 5'(data);
    @(posedge CK);
    model_edge();
    #1;
    check("Z", int'(Z), m_z);
    check("CNT", int'(CNT), m_x);
    check("BUSY", int'(BUSY), (m_state == 1) ? 1 : 0);
    check("DONE", int'(DONE), (m_state == 2) ? 1 : 0);
    check("WRAP", int'(WRAP), m_wrap);
    cnt_z0 += int'(Z[0]);
    cnt_z1 += int'(Z[1]);
    cnt_w  += int'(WRAP);
  endtask

  task automatic run(input bit p);
    step(0, p, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input int ch, input int data);
    step(0, 0, 0, 0, 0, 1, ch, data);
  endtask

  task automatic start(input bit md);
    step(0, 0, 1, 0, md, 0, 0, 0);
    cnt_z0 = 0; cnt_z1 = 0; cnt_w = 0; wrap_at = -1;
  endtask

  task automatic stop();
    step(0, 0, 0, 1, 0, 0, 0, 0);
  endtask

  initial begin
    RST = 1'b1; P_0 = 0; MODE = 0; START = 0; STOP = 0; RATE_WE = 0; RATE_CH = '0; RATE_DATA = '0;
    cnt_z0 = 0; cnt_z1 = 0; cnt_w = 0; wrap_at = -1;
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0, 0);
    check("reset_cnt", int'(CNT), 0);

    // rate bit 0: pulse on every advance
    wr(0, 5'b00001);
    start(0);
    for (int i = 0; i < 16; i++) begin
      run(1);
      if (WRAP) wrap_at = i;
    end
    check("t1_z0_count", cnt_z0, 16);
    check("t1_wrap_count", cnt_w, 1);
    check("t1_wrap_at", wrap_at, 15);
    stop();

    wr(0, 5'b00010);
    wr(1, 5'b10000);
    start(0);
    repeat (16) run(1);
    check("t2_z0_count", cnt_z0, 8);
    check("t2_z1_count", cnt_z1, 1);
    stop();

    // one-shot, weights 8+2
    wr(0, 5'b01010);
    start(1);
    repeat (16) run(1);
    check("t3_z0_count", cnt_z0, 10);
    check("t3_done", int'(DONE), 1);
    check("t3_busy", int'(BUSY), 0);
    check("t3_cnt", int'(CNT), 0);
    run(0);
    check("t3_done_drop", int'(DONE), 0);

    // P_0 toggled every cycle
    wr(0, 5'b00010);
    start(0);
    for (int i = 0; i < 32; i++) begin
      run((i % 2) == 0);
      if ((i % 2) != 0) check("t4_z_when_p0_low", int'(Z), 0);
    end
    check("t4_z0_count", cnt_z0, 8);
    check("t4_wrap_count", cnt_w, 1);
    stop();

    // rate change mid-period takes effect from the next X=0
    wr(0, 5'b00010);
    start(0);
    repeat (5) run(1);
    check("t5_cnt_at_write", int'(CNT), 5);
    step(0, 1, 0, 0, 0, 1, 0, 5'b00100);
    repeat (10) run(1);
    check("t5_old_rate_count", cnt_z0, 8);
    cnt_z0 = 0;
    repeat (16) run(1);
    check("t5_new_rate_count", cnt_z0, 4);
    stop();

    step(0, 0, 1, 1, 0, 0, 0, 0);
    check("t6_start_stop_busy", int'(BUSY), 0);

    // reset mid-run clears rates
    start(0);
    repeat (9) run(1);
    check("t7_cnt_before_rst", int'(CNT), 9);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    check("t7_rst_z", int'(Z), 0);
    check("t7_rst_busy", int'(BUSY), 0);
    start(0);
    repeat (16) run(1);
    check("t7_cleared_pulses", cnt_z0 + cnt_z1, 0);
    stop();

    for (int i = 0; i < 400; i++) begin
      step(($urandom % 100) == 0, ($urandom % 4) != 0, ($urandom % 8) == 0,
           ($urandom % 30) == 0, 1'($urandom % 2), ($urandom % 8) == 0,
           int'($urandom % 2), int'($urandom % 32));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
